boot_copy_ctrl: RTL and testbench

//  Boot sequencer between the 32x16 bootrom, main RAM and the CPU. After reset
//  (or on request) it reads every bootrom word and writes it to RAM at DEST_BASE,

---
 rtl/boot_copy_ctrl_if.sv | 33 +++
 rtl/boot_copy_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_boot_copy_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copy_ctrl_if.sv
// Bootrom read port and main-RAM port as seen by the boot copy sequencer.
interface boot_copy_ctrl_if #(
  parameter int unsigned ROM_AW = 5,
  parameter int unsigned RAM_AW = 12,
  parameter int unsigned DW     = 16
);
  logic              rom_cs;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [DW-1:0]     rom_dout;
  logic              ram_cs;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_rdata;
  logic              ram_ack;

  // Sequencer side: drives both memories' strobes, address and write data.
  modport master (
    output rom_cs, rom_we, rom_addr,
    input  rom_dout,
    output ram_cs, ram_we, ram_addr, ram_din,
    input  ram_rdata, ram_ack
  );

  // Memory side: bootrom and RAM models or wrappers.
  modport slave (
    input  rom_cs, rom_we, rom_addr,
    output rom_dout,
    input  ram_cs, ram_we, ram_addr, ram_din,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/boot_copy_ctrl.sv
// Boot copy sequencer: copies every bootrom word into main RAM at DEST_BASE
// while holding the CPU stalled, then releases the CPU and the RAM port.
// Optional macro BOOT_VERIFY_EN adds a RAM read-back pass that compares an
// XOR checksum of the written words against the read-back words.
module boot_copy_ctrl #(
  parameter int unsigned       ROM_AW    = 5,
  parameter int unsigned       WORDS     = 32,
  parameter int unsigned       RAM_AW    = 12,
  parameter int unsigned       DW        = 16,
  parameter logic [RAM_AW-1:0] DEST_BASE = '0,
  parameter int unsigned       TMO_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  boot_copy_ctrl_if.master        bus,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned      CW      = ROM_AW;
  localparam logic [CW-1:0]    LAST    = CW'(WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [2:0] {
    S_ARM,
    S_RD,
    S_WR,
    S_DONE
`ifdef BOOT_VERIFY_EN
    , S_VRD
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    data_q, data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`ifdef BOOT_VERIFY_EN
  logic [DW-1:0]    wsum_q, wsum_d;
  logic [DW-1:0]    rsum_q, rsum_d;
`else
  logic             unused_rdata;
`endif

  logic              rom_cs_q, rom_cs_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0]     ram_din_q, ram_din_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ARM;
      cnt_q   <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
`ifdef BOOT_VERIFY_EN
      wsum_q  <= '0;
      rsum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`ifdef BOOT_VERIFY_EN
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
`endif
    end
  end

  // Next-state, word counter, ack timeout and error decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tmo_d   = '0;
    err_d   = err_q;
`ifdef BOOT_VERIFY_EN
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
`endif
    case (state_q)
      S_ARM: state_d = S_RD;

      // Bootrom read is combinational; capture it at the end of the cycle.
      S_RD: begin
        data_d  = bus.rom_dout;
        state_d = S_WR;
      end

      S_WR: begin
        if (bus.ram_ack) begin
`ifdef BOOT_VERIFY_EN
          wsum_d = wsum_q ^ data_q;
`endif
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef BOOT_VERIFY_EN
            state_d = S_VRD;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_RD;
          end
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

`ifdef BOOT_VERIFY_EN
      // Read back each word; the final compare folds in the last read data.
      S_VRD: begin
        if (bus.ram_ack) begin
          rsum_d = rsum_q ^ bus.ram_rdata;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            err_d   = (rsum_d != wsum_q);
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif

      S_DONE: begin
        if (start) begin
          state_d = S_ARM;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef BOOT_VERIFY_EN
          wsum_d  = '0;
          rsum_d  = '0;
`endif
        end
      end

      default: state_d = S_ARM;
    endcase
  end

  // Output decode from the next state so registered outputs line up with state.
  always_comb begin
    rom_cs_d   = 1'b0;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    rom_addr_d = ROM_AW'(cnt_d);
    ram_addr_d = DEST_BASE + RAM_AW'(cnt_d);
    ram_din_d  = data_d;
    cpu_hold_d = 1'b1;
    done_d     = 1'b0;
    case (state_d)
      S_RD: rom_cs_d = 1'b1;
      S_WR: begin
        ram_cs_d = 1'b1;
        ram_we_d = 1'b1;
      end
`ifdef BOOT_VERIFY_EN
      S_VRD: ram_cs_d = 1'b1;
`endif
      S_DONE: begin
        cpu_hold_d = 1'b0;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers; async reset drops every strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= DEST_BASE;
      ram_din_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
    end
  end

`ifndef BOOT_VERIFY_EN
  // Read-back data is only consumed by the verify pass.
  assign unused_rdata = ^bus.ram_rdata;
`endif

  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_we   = 1'b0;
  assign bus.rom_addr = rom_addr_q;
  assign bus.ram_cs   = ram_cs_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Directed bench for boot_copy_ctrl: bootrom and RAM models, write log, checks.
module tb_boot_copy_ctrl;

  localparam int unsigned ROM_AW = 5;
  localparam int unsigned WORDS  = 32;
  localparam int unsigned RAM_AW = 12;
  localparam int unsigned DW     = 16;
  localparam int unsigned TMO_W  = 8;

  // Cycles from copy start (ARM) until done: ack tied high / ack after 3 waits.
`ifdef BOOT_VERIFY_EN
  localparam int T_FAST = 97;
  localparam int T_SLOW = 289;
`else
  localparam int T_FAST = 65;
  localparam int T_SLOW = 161;
`endif
  // ARM, RD, then 256 waiting cycles in WR.
  localparam int T_TMO = 258;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  int total = 0;
  int bad   = 0;
  int ack_mode = 0;     // 0 tied high, 1 after 3 wait cycles, 2 stuck low
  bit corrupt  = 1'b0;  // corrupt read-back of RAM word 0x005
  int wcnt     = 0;

  typedef struct packed {
    logic [RAM_AW-1:0] a;
    logic [DW-1:0]     d;
  } wr_t;

  wr_t         wr_log[$];
  logic [DW-1:0] mem [0:(1<<RAM_AW)-1];

  boot_copy_ctrl_if #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .DW(DW)) bus ();

  boot_copy_ctrl #(
    .ROM_AW(ROM_AW), .WORDS(WORDS), .RAM_AW(RAM_AW), .DW(DW),
    .DEST_BASE(12'h000), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input int i);
    case (i)
      0:       rom_word = 16'hF200;
      1:       rom_word = 16'h4000;
      31:      rom_word = 16'hC01E;
      default: rom_word = 16'h0A00 ^ 16'(i * 257);
    endcase
  endfunction

  // Bootrom: async read; garbage when deselected so stray sampling shows up.
  assign bus.rom_dout  = bus.rom_cs ? rom_word(int'(bus.rom_addr)) : 16'hDEAD;
  assign bus.ram_rdata = mem[bus.ram_addr] ^
                         ((corrupt && bus.ram_addr == 12'h005) ? 16'h0100 : 16'h0000);
  assign bus.ram_ack   = (ack_mode == 0) ? 1'b1 :
                         (ack_mode == 1) ? (bus.ram_cs && wcnt == 3) : 1'b0;

  // RAM write model and write log.
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we && bus.ram_ack) begin
      wr_log.push_back({bus.ram_addr, bus.ram_din});
      mem[bus.ram_addr] <= bus.ram_din;
    end
    if (bus.ram_cs && !bus.ram_ack) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Logged writes since base must be words 0..exp_n-1 in order with ROM data.
  task automatic check_log(input string tag, input int base, input int exp_n);
    int mism = 0;
    chk({tag, "_nwr"}, wr_log.size() - base, exp_n);
    for (int k = base; k < wr_log.size(); k++)
      if (wr_log[k].a != 12'(k - base) || wr_log[k].d != rom_word(k - base)) mism++;
    chk({tag, "_img"}, mism, 0);
  endtask

  // Wait for done with a cycle budget; optionally poke start mid-copy and
  // check write address/data stability while the RAM has not acked.
  task automatic wait_done(input string tag, input int budget, input int poke,
                           input bit stab, output int n);
    bit              hold_bad = 1'b0;
    int              unstable = 0;
    logic            pw = 1'b0;
    logic [RAM_AW-1:0] pa = '0;
    logic [DW-1:0]   pd = '0;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (pw && (bus.ram_addr != pa || bus.ram_din != pd)) unstable++;
      pw = bus.ram_cs && bus.ram_we && !bus.ram_ack;
      pa = bus.ram_addr;
      pd = bus.ram_din;
      start = (poke > 0) && (n == poke || n == poke + 1);
      if (done) break;
      if (!cpu_hold) hold_bad = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_hold_during"}, 32'(hold_bad), 0);
    chk({tag, "_hold_rel"}, 32'(cpu_hold), 0);
    if (stab) chk({tag, "_stable"}, unstable, 0);
  endtask

  initial begin
    int n;
    int base;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hold",    32'(cpu_hold), 1);
    chk("rst_done",    32'(done), 0);
    chk("rst_err",     32'(err), 0);
    chk("rst_rom_cs",  32'(bus.rom_cs), 0);
    chk("rst_ram_cs",  32'(bus.ram_cs), 0);
    chk("rst_ram_we",  32'(bus.ram_we), 0);
    chk("rst_rom_adr", 32'(bus.rom_addr), 0);
    chk("rst_ram_adr", 32'(bus.ram_addr), 32'h000);
    chk("rst_ram_din", 32'(bus.ram_din), 0);

    // Test 1: full copy with ack tied high
    base = wr_log.size();
    rst  = 1'b0;
    wait_done("t1", 400, 0, 1'b0, n);
    chk("t1_cycles", n, T_FAST);
    chk("t1_err", 32'(err), 0);
    chk("t1_rom_we", 32'(bus.rom_we), 0);
    check_log("t1", base, WORDS);

    // Test 2: ack after 3 wait cycles per access
    ack_mode = 1;
    rst = 1'b1;
    @(negedge clk);
    base = wr_log.size();
    rst  = 1'b0;
    wait_done("t2", 800, 0, 1'b1, n);
    chk("t2_cycles", n, T_SLOW);
    chk("t2_err", 32'(err), 0);
    check_log("t2", base, WORDS);

    // Test 4: reset while writing word 0x00A
    ack_mode = 0;
    rst = 1'b1;
    @(negedge clk);
    base = wr_log.size();
    rst  = 1'b0;
    n = 0;
    while (n < 100 && !(bus.ram_we && bus.ram_addr == 12'h00A)) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach", 32'(bus.ram_addr), 32'h00A);
    rst = 1'b1;
    #1;
    chk("t4_ram_cs", 32'(bus.ram_cs), 0);
    chk("t4_ram_we", 32'(bus.ram_we), 0);
    chk("t4_rom_cs", 32'(bus.rom_cs), 0);
    chk("t4_hold",   32'(cpu_hold), 1);
    chk("t4_nwr_pre", wr_log.size() - base, 10);
    @(negedge clk);
    base = wr_log.size();
    rst  = 1'b0;
    wait_done("t4", 400, 0, 1'b0, n);
    chk("t4_cycles", n, T_FAST);
    check_log("t4", base, WORDS);

    // Test 5: ack stuck low -> timeout
    ack_mode = 2;
    rst = 1'b1;
    @(negedge clk);
    base = wr_log.size();
    rst  = 1'b0;
    wait_done("t5", 600, 0, 1'b0, n);
    chk("t5_cycles", n, T_TMO);
    chk("t5_err", 32'(err), 1);
    repeat (5) @(negedge clk);
    chk("t5_ram_we", 32'(bus.ram_we), 0);
    chk("t5_done_hold", 32'(done), 1);
    chk("t5_nwr", wr_log.size() - base, 0);

    // Test 3: start in DONE re-runs; start pokes during RD/WR are ignored
    ack_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_err_clr",  32'(err), 0);
    chk("t3_done_clr", 32'(done), 0);
    chk("t3_hold",     32'(cpu_hold), 1);
    base = wr_log.size();
    wait_done("t3", 400, 9, 1'b0, n);
    chk("t3_cycles", n, T_FAST);
    chk("t3_err", 32'(err), 0);
    check_log("t3", base, WORDS);

`ifdef BOOT_VERIFY_EN
    // Test 6: verify pass catches a corrupted word, passes on clean RAM
    corrupt = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_done("t6a", 400, 0, 1'b0, n);
    chk("t6a_cycles", n, T_FAST);
    chk("t6a_err", 32'(err), 1);
    corrupt = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6b", 400, 0, 1'b0, n);
    chk("t6b_cycles", n, T_FAST);
    chk("t6b_err", 32'(err), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
